// File: rtl/rgby_pkg.sv
// Shared color codes, filter-select encodings and FSM states for the RGBY classifier.
package rgby_pkg;

  // Classification result codes
  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] GREEN  = 2'd1;
  localparam logic [1:0] BLUE   = 2'd2;
  localparam logic [1:0] YELLOW = 2'd3;

  // TCS3200 {S2,S3} filter selects
  localparam logic [1:0] FILT_R   = 2'b00;
  localparam logic [1:0] FILT_G   = 2'b11;
  localparam logic [1:0] FILT_B   = 2'b01;
  localparam logic [1:0] FILT_CLR = 2'b10;

  typedef enum logic [3:0] {
    StIdle,
    StSettleR,
    StGateR,
    StSettleG,
    StGateG,
    StSettleB,
    StGateB,
    StClassify,
    StDone
  } state_t;

endpackage

// File: rtl/freq_gate_counter.sv
// Synchronises the raw sensor wave, detects rising edges and counts them into a
// saturating counter. o_count already includes any edge counted on this cycle, so the
// owner can latch it on the last cycle of a gate window.
module freq_gate_counter #(
  parameter int unsigned CNT_W = 12
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_freq_in,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_count
);

  logic [1:0]       r_sync;
  logic             r_prev;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             w_edge;

  // Two-flop synchroniser followed by a delayed copy for edge detection
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync <= 2'b00;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_freq_in};
      r_prev <= r_sync[1];
    end
  end

  assign w_edge = r_sync[1] & ~r_prev;

  // Next count: clear wins, otherwise count enabled edges and stop at all-ones
  always_comb begin
    w_count_next = r_count;
    if (i_clear) begin
      w_count_next = '0;
    end else if (i_enable && w_edge && (r_count != {CNT_W{1'b1}})) begin
      w_count_next = r_count + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_count = w_count_next;

endmodule

// File: rtl/color_classifier.sv
// Sequences the sensor through red, green and blue filters, counts edges in a fixed
// window for each, then classifies the reading as one of four RGBY codes.
module color_classifier
  import rgby_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = 2000,
  parameter int unsigned SETTLE_CYCLES = 100,
  parameter int unsigned CNT_W         = 12
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_freq_in,
  output logic [1:0] o_color_select,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_color,
  output logic [7:0] o_freq_count
);

  localparam int unsigned MaxWin = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TW = $clog2(MaxWin) + 1;
  localparam logic [TW-1:0] SettleLast = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] GateLast   = TW'(GATE_CYCLES - 1);

  state_t           r_state, w_state_next;
  logic [TW-1:0]    r_timer;
  logic             w_clear, w_enable;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] r_cnt_r, r_cnt_g, r_cnt_b;
  logic [1:0]       r_color, w_color;
  logic [7:0]       r_freq, w_freq;

  // Widened by one bit so x + (x >> 2) cannot overflow
  logic [CNT_W:0]   w_r, w_g, w_b, w_r_adj, w_g_adj;
  logic [CNT_W-1:0] w_win;
  logic [CNT_W+7:0] w_win_ext;
  logic             w_yellow;

  freq_gate_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_freq_in(i_freq_in),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .o_count  (w_count)
  );

  // State register and per-state cycle timer (restarts on every state change)
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_timer <= '0;
    end else begin
      r_state <= w_state_next;
      if ((w_state_next != r_state) || (r_state == StIdle)) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TW'(1);
      end
    end
  end

  // Next-state, counter control and filter/handshake outputs
  always_comb begin
    w_state_next   = r_state;
    w_clear        = 1'b0;
    w_enable       = 1'b0;
    o_color_select = FILT_CLR;
    o_busy         = 1'b1;
    o_done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_busy = 1'b0;
        if (i_start) w_state_next = StSettleR;
      end
      StSettleR: begin
        o_color_select = FILT_R;
        w_clear        = 1'b1;
        if (r_timer == SettleLast) w_state_next = StGateR;
      end
      StGateR: begin
        o_color_select = FILT_R;
        w_enable       = 1'b1;
        if (r_timer == GateLast) w_state_next = StSettleG;
      end
      StSettleG: begin
        o_color_select = FILT_G;
        w_clear        = 1'b1;
        if (r_timer == SettleLast) w_state_next = StGateG;
      end
      StGateG: begin
        o_color_select = FILT_G;
        w_enable       = 1'b1;
        if (r_timer == GateLast) w_state_next = StSettleB;
      end
      StSettleB: begin
        o_color_select = FILT_B;
        w_clear        = 1'b1;
        if (r_timer == SettleLast) w_state_next = StGateB;
      end
      StGateB: begin
        o_color_select = FILT_B;
        w_enable       = 1'b1;
        if (r_timer == GateLast) w_state_next = StClassify;
      end
      StClassify: w_state_next = StDone;
      StDone: begin
        o_done       = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Capture each channel's count on the last cycle of its gate window
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt_r <= '0;
      r_cnt_g <= '0;
      r_cnt_b <= '0;
    end else if (r_timer == GateLast) begin
      if (r_state == StGateR) r_cnt_r <= w_count;
      if (r_state == StGateG) r_cnt_g <= w_count;
      if (r_state == StGateB) r_cnt_b <= w_count;
    end
  end

  assign w_r      = {1'b0, r_cnt_r};
  assign w_g      = {1'b0, r_cnt_g};
  assign w_b      = {1'b0, r_cnt_b};
  assign w_r_adj  = w_r + (w_r >> 2);
  assign w_g_adj  = w_g + (w_g >> 2);
  assign w_yellow = (w_r > w_b) && (w_g > w_b) && (w_g_adj >= w_r) && (w_r_adj >= w_g);

  // Classification: yellow when red and green are close and both beat blue,
  // otherwise the largest count with ties resolved red > green > blue
  always_comb begin
    w_color = RED;
    w_win   = r_cnt_r;
    if (w_yellow) begin
      w_color = YELLOW;
      w_win   = r_cnt_r;
    end else if ((w_r >= w_g) && (w_r >= w_b)) begin
      w_color = RED;
      w_win   = r_cnt_r;
    end else if (w_g >= w_b) begin
      w_color = GREEN;
      w_win   = r_cnt_g;
    end else begin
      w_color = BLUE;
      w_win   = r_cnt_b;
    end
  end

  assign w_win_ext = {8'b0, w_win};
  assign w_freq    = (w_win_ext > (CNT_W + 8)'(255)) ? 8'hFF : w_win_ext[7:0];

  // Result registers, loaded on entry to DONE and held until the next result
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_color <= RED;
      r_freq  <= 8'd0;
    end else if (r_state == StClassify) begin
      r_color <= w_color;
      r_freq  <= w_freq;
    end
  end

  assign o_color      = r_color;
  assign o_freq_count = r_freq;

endmodule

// File: tb/tb_color_classifier.sv
// Self-checking bench: randomized sensor waveforms per filter, a behavioural model of
// the measurement and classification, and a scoreboard consumed on every done strobe.
module tb_color_classifier;

  localparam int G    = 200;
  localparam int S    = 10;
  localparam int W    = 6;
  localparam int WIN  = S + G;       // samples per filter (settle + gate)
  localparam int N    = 3 * WIN;     // samples spent measuring
  localparam int LAT  = N + 2;       // start edge to done edge
  localparam int CMAX = (1 << W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       fin = 1'b0;
  logic [1:0] sel;
  logic       busy, done;
  logic [1:0] color;
  logic [7:0] fcount;

  color_classifier #(
    .GATE_CYCLES  (G),
    .SETTLE_CYCLES(S),
    .CNT_W        (W)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_start       (start),
    .i_freq_in     (fin),
    .o_color_select(sel),
    .o_busy        (busy),
    .o_done        (done),
    .o_color       (color),
    .o_freq_count  (fcount)
  );

  always #5 clk = ~clk;

  // Index of the most recent rising clock edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int color;
    int fc;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  // v[m] is the sensor level driven just after edge m-1, i.e. sampled on edge m,
  // where edge 0 is the one that accepts start
  int   v[0:N+2];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lvl(input int m, input int p, input int ph);
    if (p == 0) return 0;
    return (((m + ph) % p) < (p / 2)) ? 1 : 0;
  endfunction

  // Sensor waveform: the period follows the filter the DUT should be selecting
  task automatic build(input int pr, input int pg, input int pb);
    int p[3];
    int ph[3];
    p = '{pr, pg, pb};
    for (int c = 0; c < 3; c++) ph[c] = int'($urandom_range(0, 31));
    for (int m = 0; m <= N + 2; m++) v[m] = 0;
    for (int m = 1; m <= N; m++) begin
      int c;
      c = (m - 1) / WIN;
      v[m] = lvl(m, p[c], ph[c]);
    end
  endtask

  // Reference: a rise sampled on edge m is counted on edge m+2 (three clocks after the
  // input changes); channel c counts on edges inside its gate window only
  function automatic exp_t model(input int k0);
    exp_t e;
    int cnt[3];
    int r, g, b, win;
    cnt = '{0, 0, 0};
    for (int m = 1; m <= N; m++) begin
      if (v[m] == 1 && v[m-1] == 0) begin
        for (int c = 0; c < 3; c++) begin
          if ((m + 2 >= c * WIN + S + 1) && (m + 2 <= (c + 1) * WIN)) cnt[c]++;
        end
      end
    end
    r = (cnt[0] > CMAX) ? CMAX : cnt[0];
    g = (cnt[1] > CMAX) ? CMAX : cnt[1];
    b = (cnt[2] > CMAX) ? CMAX : cnt[2];
    if (r > b && g > b && (g + g / 4) >= r && (r + r / 4) >= g) begin
      e.color = 3;
      win = r;
    end else if (r >= g && r >= b) begin
      e.color = 0;
      win = r;
    end else if (g >= b) begin
      e.color = 1;
      win = g;
    end else begin
      e.color = 2;
      win = b;
    end
    e.fc  = (win > 255) ? 255 : win;
    e.cyc = k0 + LAT;
    return e;
  endfunction

  function automatic int filt_of(input int m);
    int c;
    c = (m - 1) / WIN;
    return (c == 0) ? 0 : (c == 1) ? 3 : 1;
  endfunction

  // One classification; i0..i2 are extra start pulses (by sample index) to be ignored
  task automatic run(input int pr, input int pg, input int pb,
                     input int i0, input int i1, input int i2, input bit chk_sel);
    exp_t e;
    build(pr, pg, pb);
    e = model(cyc + 1);
    sb.push_back(e);
    chk("sel_idle", int'(sel), 2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int m = 1; m <= N + 2; m++) begin
      fin   = v[m][0];
      start = (m == i0 || m == i1 || m == i2);
      if (m == 1) chk("busy_running", int'(busy), 1);
      if (chk_sel && m <= N && ((m - 1) % WIN == 0 || m % WIN == 0))
        chk("color_select", int'(sel), filt_of(m));
      @(posedge clk); #1;
    end
    start = 1'b0;
    fin   = 1'b0;
    chk("busy_after_done", int'(busy), 0);
    chk("done_after_done", int'(done), 0);
  endtask

  // Start a run, then assert reset part-way through and check the idle state
  task automatic run_reset(input int cut);
    build(4, 5, 20);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int m = 1; m <= cut; m++) begin
      fin = v[m][0];
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sel", int'(sel), 2);
    chk("rst_color", int'(color), 0);
    chk("rst_fcount", int'(fcount), 0);
    fin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: every done strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL done_unexpected: got done=1, expected no done (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("color", int'(color), mon_e.color);
        chk("freq_count", int'(fcount), mon_e.fc);
        chk("done_cycle", cyc + 1, mon_e.cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_sel", int'(sel), 2);
    chk("reset_color", int'(color), 0);
    chk("reset_fcount", int'(fcount), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(4, 20, 20, 0, 0, 0, 1'b1);         // red dominant
    run(4, 5, 20, 0, 0, 0, 1'b0);          // red and green close: yellow
    run(4, 7, 20, 0, 0, 0, 1'b0);          // green too far below red
    run(2, 2, 2, 0, 0, 0, 1'b0);           // all channels saturate, tie goes to red
    run(0, 0, 6, 0, 0, 0, 1'b1);           // only blue light
    run(20, 5, 20, 50, N + 1, N + 2, 1'b0);  // ignored starts while busy and on DONE
    run(6, 20, 3, 0, 0, 0, 1'b0);          // back-to-back on the first idle cycle
    run_reset(WIN + S + 50);               // reset inside the green gate
    chk("post_reset_color", int'(color), 0);
    run(5, 4, 20, 0, 0, 0, 1'b1);          // fresh run after reset
    for (int i = 0; i < 8; i++) begin
      int p[3];
      for (int c = 0; c < 3; c++) begin
        p[c] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 25));
      end
      run(p[0], p[1], p[2], int'($urandom_range(1, N)), 0, 0, 1'b0);
    end

    repeat (20) @(posedge clk);
    #1;
    chk("pending_done", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
